// File: rtl/tw_addr_gen.sv
// tw_addr_gen: per-stage twiddle ROM read-address generator with latency-matched valid/done.
// Optional build macro TW_ADDR_BITREV_EN: bit-reverse the STAGE-bit address field
// (ROM stored in bit-reversed order); latency and handshakes are unchanged.
module tw_addr_gen #(
    parameter int LOGN        = 12,
    parameter int STAGE       = 1,
    parameter int DELAY_BROM  = 2,
    parameter int ALIGN_EXTRA = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            intt_in,
    input  logic            in_valid,
    output logic [LOGN-1:0] raddr,
    output logic            intt,
    output logic            tw_valid,
    output logic            busy,
    output logic            done
);
    // Twiddle latency through the ROM wrapper; the valid line also covers the raddr register.
    localparam int L  = DELAY_BROM + ALIGN_EXTRA;
    localparam int SH = LOGN - 1 - STAGE;
    localparam logic [LOGN-2:0] CNT_LAST = '1;
    localparam logic [LOGN-2:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [LOGN-2:0] cnt_q, cnt_d, fld, rev;
    logic [LOGN-1:0] raddr_q, raddr_d;
    logic            intt_q, intt_d, busy_q, busy_d;
    logic [L:0]      vld_q, vld_d, last_q, last_d;
    logic            issue;

    assign issue = (state_q == RUN) && in_valid;

    // Address field of the current butterfly count, in ROM storage order.
    always_comb begin
        fld = cnt_q >> SH;
`ifdef TW_ADDR_BITREV_EN
        rev = '0;
        for (int i = 0; i < STAGE; i++) rev[i] = fld[STAGE-1-i];
`else
        rev = fld;
`endif
    end

    // Next-state logic: pass control, counting, address issue and the valid/last delay lines.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        raddr_d   = raddr_q;
        intt_d    = intt_q;
        busy_d    = busy_q;
        vld_d     = vld_q << 1;
        vld_d[0]  = issue;
        last_d    = last_q << 1;
        last_d[0] = issue && (cnt_q == CNT_LAST);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    intt_d  = intt_in;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (in_valid) begin
                    raddr_d = {1'b0, rev};
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = (cnt_q == CNT_LAST) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (last_q[L]) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts a pass immediately and flushes in-flight tokens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            raddr_q <= '0;
            intt_q  <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            intt_q  <= intt_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    assign raddr    = raddr_q;
    assign intt     = intt_q;
    assign tw_valid = vld_q[L];
    assign busy     = busy_q;
    assign done     = last_q[L];
endmodule
